// File: rtl/exe_pkg.sv
// Shared definitions for the MIPS execute stage: default datapath width,
// ALU opcode encodings and the immediate sign-extension helper.
package exe_pkg;

    // Default datapath width of the execute stage.
    localparam int EXE_WIDTH = 32;

    // Widest datapath the sign-extension helper covers; callers size-cast down.
    localparam int SEXT_MAX = 64;

    // ALU opcode encodings issued by decode.
    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_XOR  = 4'b0011,
        ALU_SLL  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_SUB  = 4'b0110,
        ALU_SLT  = 4'b0111,
        ALU_SRA  = 4'b1000,
        ALU_SLTU = 4'b1001,
        ALU_LUI  = 4'b1010,
        ALU_NOR  = 4'b1100
    } alu_op_e;

    // Sign-extend a 16-bit instruction immediate to SEXT_MAX bits.
    function automatic logic [SEXT_MAX-1:0] sext16(input logic [15:0] imm);
        return {{(SEXT_MAX-16){imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/exe_alu.sv
// Combinational ALU of the MIPS execute stage.
// With EXE_OVF_EN defined it also reports signed overflow for ADD/SUB.
module exe_alu
    import exe_pkg::*;
#(
    parameter int WIDTH = EXE_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_op,
    output logic [WIDTH-1:0] r
`ifdef EXE_OVF_EN
    ,
    output logic             ovf
`endif
);

    // Only the low log2(WIDTH) bits of A select the shift distance.
    localparam int SHW = $clog2(WIDTH);

    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    alu_op_e          op;

    assign shamt = a[SHW-1:0];
    assign sum   = a + b;
    assign diff  = a - b;
    assign op    = alu_op_e'(alu_op);

    // Select the result for the current opcode; unused codes yield zero.
    always_comb begin
        r = '0;
        case (op)
            ALU_AND:  r = a & b;
            ALU_OR:   r = a | b;
            ALU_ADD:  r = sum;
            ALU_XOR:  r = a ^ b;
            ALU_SLL:  r = b << shamt;
            ALU_SRL:  r = b >> shamt;
            ALU_SUB:  r = diff;
            ALU_SLT:  r = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SRA:  r = $signed(b) >>> shamt;
            ALU_SLTU: r = {{(WIDTH-1){1'b0}}, (a < b)};
            ALU_LUI:  r = b << 16;
            ALU_NOR:  r = ~(a | b);
            default:  r = '0;
        endcase
    end

`ifdef EXE_OVF_EN
    // Signed overflow: ADD when equal-sign operands give a different-sign
    // result, SUB when different-sign operands flip the sign of A.
    always_comb begin
        ovf = 1'b0;
        case (op)
            ALU_ADD: ovf = ~(a[WIDTH-1] ^ b[WIDTH-1]) & (sum[WIDTH-1] ^ a[WIDTH-1]);
            ALU_SUB: ovf = (a[WIDTH-1] ^ b[WIDTH-1]) & (diff[WIDTH-1] ^ a[WIDTH-1]);
            default: ovf = 1'b0;
        endcase
    end
`endif

endmodule

// File: rtl/mips_exe_stage.sv
// Execute stage of the 32-bit MIPS pipeline: operand-B mux, ALU and a
// one-cycle output register (result plus zero flag).
// Optional feature macro: EXE_OVF_EN adds a registered signed-overflow flag.
// WIDTH must lie between 16 and SEXT_MAX (64).
module mips_exe_stage
    import exe_pkg::*;
#(
    parameter int WIDTH = EXE_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ALUSrc,
    input  logic [3:0]       ALUOp,
    input  logic [15:0]      Immediate,
    input  logic [WIDTH-1:0] Reg1,
    input  logic [WIDTH-1:0] Reg2,
    output logic [WIDTH-1:0] ALUOut,
    output logic             zero
`ifdef EXE_OVF_EN
    ,
    output logic             ovf
`endif
);

    logic [WIDTH-1:0] imm_ext;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] result;

    assign imm_ext = WIDTH'(sext16(Immediate));

    // Operand B is either rt data or the sign-extended immediate.
    always_comb begin
        op_b = Reg2;
        if (ALUSrc) begin
            op_b = imm_ext;
        end
    end

`ifdef EXE_OVF_EN
    logic ovf_c;

    exe_alu #(.WIDTH(WIDTH)) u_alu (
        .a      (Reg1),
        .b      (op_b),
        .alu_op (ALUOp),
        .r      (result),
        .ovf    (ovf_c)
    );

    // Register the overflow flag alongside the result; reset clears it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ovf <= 1'b0;
        end else begin
            ovf <= ovf_c;
        end
    end
`else
    exe_alu #(.WIDTH(WIDTH)) u_alu (
        .a      (Reg1),
        .b      (op_b),
        .alu_op (ALUOp),
        .r      (result)
    );
`endif

    // Register result and zero flag every cycle; reset wins over any result.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ALUOut <= '0;
            zero   <= 1'b1;
        end else begin
            ALUOut <= result;
            zero   <= (result == '0);
        end
    end

endmodule

// File: tb/tb_mips_exe_stage.sv
// Directed, table-driven bench for mips_exe_stage (WIDTH = 32).
// Build with +define+EXE_OVF_EN to also check the overflow flag.
module tb_mips_exe_stage;

  localparam int W = 32;

  typedef struct {
    string        name;
    logic         alusrc;
    logic [3:0]   aluop;
    logic [15:0]  imm;
    logic [W-1:0] reg1;
    logic [W-1:0] reg2;
    logic [W-1:0] exp_out;
    logic         exp_zero;
    logic         exp_ovf;
  } vec_t;

  logic         clk;
  logic         rst;
  logic         ALUSrc;
  logic [3:0]   ALUOp;
  logic [15:0]  Immediate;
  logic [W-1:0] Reg1;
  logic [W-1:0] Reg2;
  logic [W-1:0] ALUOut;
  logic         zero;
`ifdef EXE_OVF_EN
  logic         ovf;
`endif

  int checks;
  int errors;

  vec_t vecs[$];

  mips_exe_stage #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .ALUSrc    (ALUSrc),
    .ALUOp     (ALUOp),
    .Immediate (Immediate),
    .Reg1      (Reg1),
    .Reg2      (Reg2),
    .ALUOut    (ALUOut),
    .zero      (zero)
`ifdef EXE_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  // Clock: 10 time-unit period, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_word(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  // Drive inputs just after a falling edge so they are stable at the next rising edge.
  task automatic drive(input logic src, input logic [3:0] op, input logic [15:0] imm,
                       input logic [W-1:0] r1, input logic [W-1:0] r2);
    @(negedge clk);
    ALUSrc    = src;
    ALUOp     = op;
    Immediate = imm;
    Reg1      = r1;
    Reg2      = r2;
  endtask

  task automatic drive_random();
    drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 16'($urandom()),
          W'($urandom()), W'($urandom()));
  endtask

  // Wait for the capturing edge and sample shortly after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs(input string name, input logic [W-1:0] exp_out,
                               input logic exp_zero, input logic exp_ovf);
    check_word({name, ".out"}, ALUOut, exp_out);
    check_bit({name, ".zero"}, zero, exp_zero);
`ifdef EXE_OVF_EN
    check_bit({name, ".ovf"}, ovf, exp_ovf);
`else
    if (exp_ovf === 1'bx) $display("unexpected unknown overflow expectation in %s", name);
`endif
  endtask

  task automatic add_vec(input string name, input logic src, input logic [3:0] op,
                         input logic [15:0] imm, input logic [W-1:0] r1, input logic [W-1:0] r2,
                         input logic [W-1:0] e_out, input logic e_ovf);
    vec_t v;
    v.name     = name;
    v.alusrc   = src;
    v.aluop    = op;
    v.imm      = imm;
    v.reg1     = r1;
    v.reg2     = r2;
    v.exp_out  = e_out;
    v.exp_zero = (e_out == '0);
    v.exp_ovf  = e_ovf;
    vecs.push_back(v);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b0;
    ALUSrc    = 1'b0;
    ALUOp     = 4'b0000;
    Immediate = 16'h0000;
    Reg1      = '0;
    Reg2      = '0;

    // Hand-computed vectors: name, ALUSrc, ALUOp, Immediate, Reg1, Reg2, ALUOut, ovf
    add_vec("add_reg",      1'b0, 4'b0010, 16'h0000, 32'h0000_0005, 32'h0000_0003, 32'h0000_0008, 1'b0);
    add_vec("add_imm_neg",  1'b1, 4'b0010, 16'hFFFF, 32'h0000_0010, 32'h1234_5678, 32'h0000_000F, 1'b0);
    add_vec("add_imm_sext", 1'b1, 4'b0010, 16'h8000, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_8000, 1'b0);
    add_vec("sub_equal",    1'b0, 4'b0110, 16'h0000, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b0);
    add_vec("sub_neg",      1'b0, 4'b0110, 16'h0000, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1'b0);
    add_vec("sub_imm",      1'b1, 4'b0110, 16'h0001, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0);
    add_vec("slt_neg_pos",  1'b0, 4'b0111, 16'h0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0);
    add_vec("slt_pos_neg",  1'b0, 4'b0111, 16'h0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
    add_vec("slt_neg_neg",  1'b0, 4'b0111, 16'h0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    add_vec("sltu_big",     1'b0, 4'b1001, 16'h0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0);
    add_vec("sltu_small",   1'b0, 4'b1001, 16'h0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    add_vec("sll_out",      1'b0, 4'b0100, 16'h0000, 32'h0000_0004, 32'h8000_0000, 32'h0000_0000, 1'b0);
    add_vec("sll_low_bits", 1'b0, 4'b0100, 16'h0000, 32'h0000_0021, 32'h0000_0003, 32'h0000_0006, 1'b0);
    add_vec("srl_msb",      1'b0, 4'b0101, 16'h0000, 32'h0000_0004, 32'h8000_0000, 32'h0800_0000, 1'b0);
    add_vec("srl_31",       1'b0, 4'b0101, 16'h0000, 32'h0000_001F, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    add_vec("sra_neg",      1'b0, 4'b1000, 16'h0000, 32'h0000_0004, 32'h8000_0000, 32'hF800_0000, 1'b0);
    add_vec("sra_pos",      1'b0, 4'b1000, 16'h0000, 32'h0000_0024, 32'h4000_0000, 32'h0400_0000, 1'b0);
    add_vec("lui_imm",      1'b1, 4'b1010, 16'h1234, 32'h0000_0005, 32'h0000_0000, 32'h1234_0000, 1'b0);
    add_vec("lui_reg",      1'b0, 4'b1010, 16'h0000, 32'h0000_0007, 32'h0000_ABCD, 32'hABCD_0000, 1'b0);
    add_vec("and",          1'b0, 4'b0000, 16'h0000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0);
    add_vec("or",           1'b0, 4'b0001, 16'h0000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0, 1'b0);
    add_vec("xor",          1'b0, 4'b0011, 16'h0000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00, 1'b0);
    add_vec("nor_zero",     1'b0, 4'b1100, 16'h0000, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0);
    add_vec("nor_mix",      1'b0, 4'b1100, 16'h0000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h000F_000F, 1'b0);
    add_vec("undef_1111",   1'b0, 4'b1111, 16'h0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
    add_vec("undef_1011",   1'b0, 4'b1011, 16'h0000, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 1'b0);
    add_vec("undef_1101",   1'b0, 4'b1101, 16'h0000, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 1'b0);
    add_vec("undef_1110",   1'b0, 4'b1110, 16'h0000, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 1'b0);
    add_vec("add_ovf",      1'b0, 4'b0010, 16'h0000, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b1);
    add_vec("add_neg_ovf",  1'b0, 4'b0010, 16'h0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 1'b1);
    add_vec("add_wrap_ok",  1'b0, 4'b0010, 16'h0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0);
    add_vec("sub_ovf",      1'b0, 4'b0110, 16'h0000, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1);
    add_vec("sub_no_ovf",   1'b0, 4'b0110, 16'h0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0);
    add_vec("or_no_ovf",    1'b0, 4'b0001, 16'h0000, 32'h7FFF_FFFF, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0);

    // Reset with random inputs: result cleared, zero set.
    drive_random();
    rst = 1'b0;
    step();
    check_outputs("reset", 32'h0000_0000, 1'b1, 1'b0);

    // Release reset: the very next edge computes normally.
    drive(1'b0, 4'b0010, 16'h0000, 32'h0000_0005, 32'h0000_0003);
    rst = 1'b1;
    step();
    check_outputs("post_reset", 32'h0000_0008, 1'b0, 1'b0);

    // Table: one vector per cycle, each visible right after its capturing edge.
    foreach (vecs[i]) begin
      drive(vecs[i].alusrc, vecs[i].aluop, vecs[i].imm, vecs[i].reg1, vecs[i].reg2);
      step();
      check_outputs(vecs[i].name, vecs[i].exp_out, vecs[i].exp_zero, vecs[i].exp_ovf);
    end

    // Outputs hold between edges even when inputs change mid-cycle.
    drive(1'b0, 4'b1100, 16'h0000, 32'h0000_0000, 32'h0000_0000);
    step();
    #2;
    ALUOp = 4'b0000;
    Reg1  = 32'h1111_1111;
    #1;
    check_outputs("hold_between_edges", 32'hFFFF_FFFF, 1'b0, 1'b0);

    // Reset has priority over an in-flight overflowing result.
    drive(1'b0, 4'b0010, 16'h0000, 32'h7FFF_FFFF, 32'h0000_0001);
    rst = 1'b0;
    step();
    check_outputs("reset_priority", 32'h0000_0000, 1'b1, 1'b0);

    // Release again and confirm back-to-back results with no stall.
    drive(1'b1, 4'b0010, 16'h0001, 32'h0000_0010, 32'h0000_0000);
    rst = 1'b1;
    step();
    check_outputs("b2b_first", 32'h0000_0011, 1'b0, 1'b0);
    drive(1'b0, 4'b0110, 16'h0000, 32'h0000_0011, 32'h0000_0011);
    step();
    check_outputs("b2b_second", 32'h0000_0000, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
